// File: rtl/fir_pkg.sv
// FIR controller shared types and sizing constants.
// Imported by the tap counter and the controller FSM.
package fir_pkg;

  localparam int FIR_SIZE = 64;
  localparam int ADDR_W   = 6;
  localparam int IN_W     = 16;
  localparam int OUT_W    = 38;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DRAIN,
    DONE
  } fir_state_t;

endpackage

// File: rtl/fir_controller_tap_counter.sv
// Tap index counter for the FIR sweep, modulo N.
// Ports: clk, rst (async high), clr, en -> cnt, tc (cnt==N-1).
module tap_counter
  import fir_pkg::*;
#(
  parameter int N = FIR_SIZE,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc  = (cnt_q == W'(N - 1));
  assign cnt = cnt_q;

  // clear wins over enable
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_controller.sv
// FIR controller: accepts a sample, sweeps taps, drains, hands off result.
// Ports: clk, rst, in_valid/in_ready, out_valid/out_ready,
//        shift, flush, freeze, address, busy.
module fir_controller
  import fir_pkg::*;
#(
  parameter int FIR_size  = FIR_SIZE,
  parameter int AddrWidth = $clog2(FIR_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 shift,
  output logic                 flush,
  output logic                 freeze,
  output logic [AddrWidth-1:0] address,
  output logic                 busy
);

  fir_state_t state_q;
  fir_state_t state_d;

  logic [AddrWidth-1:0] cnt;
  logic                 tc;
  logic                 cnt_clr;
  logic                 cnt_en;

  tap_counter #(
    .N (FIR_size),
    .W (AddrWidth)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (cnt),
    .tc  (tc)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    shift     = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b1;
    address   = '0;
    busy      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid & in_ready) begin
          shift   = 1'b1;
          flush   = 1'b1;
          freeze  = 1'b0;
          cnt_clr = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        freeze  = 1'b0;
        address = cnt;
        busy    = 1'b1;
        cnt_en  = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        address = AddrWidth'(FIR_size - 1);
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = ~rst & out_ready;
        if (out_ready) begin
          if (in_valid) begin
            // back-to-back: result handed off and new sample taken together
            shift   = 1'b1;
            flush   = 1'b1;
            cnt_clr = 1'b1;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_fir_controller.sv
// Randomized scoreboard bench for fir_controller.
// Reference model tracks elapsed cycles since each accepted sample.
module tb_fir_controller;
  import fir_pkg::*;

  localparam int N   = FIR_SIZE;
  localparam int LAT = N + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              shift;
  logic              flush;
  logic              freeze;
  logic [ADDR_W-1:0] address;
  logic              busy;

  fir_controller #(
    .FIR_size  (N),
    .AddrWidth (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift     (shift),
    .flush     (flush),
    .freeze    (freeze),
    .address   (address),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // reference model: idle, running for 65 cycles after accept, or done
  typedef enum {M_IDLE, M_RUN, M_DONE} mmode_t;
  mmode_t mode = M_IDLE;
  int t0 = 0;
  int exp_q[$];
  int m_hs = 0;

  always @(negedge clk) begin
    bit e_ir, e_sh, e_fz, e_ov, e_bz, a;
    int e_ad, p;
    e_ir = 0; e_sh = 0; e_fz = 1; e_ov = 0; e_bz = 0; e_ad = 0; a = 0;
    if (rst) begin
      mode = M_IDLE;
      exp_q.delete();
    end else begin
      case (mode)
        M_IDLE: begin
          e_ir = 1;
          a    = in_valid;
          e_fz = !a;
        end
        M_RUN: begin
          p    = cyc - t0;
          e_bz = 1;
          if (p <= N) begin
            e_fz = 0;
            e_ad = p - 1;
          end else begin
            e_ad = N - 1;
          end
        end
        default: begin
          e_ov = 1;
          e_ir = out_ready;
          a    = in_valid && out_ready;
        end
      endcase
      e_sh = a;
    end
    chk("in_ready", in_ready, e_ir);
    chk("shift", shift, e_sh);
    chk("flush", flush, e_sh);
    chk("freeze", freeze, e_fz);
    chk("address", address, e_ad);
    chk("out_valid", out_valid, e_ov);
    chk("busy", busy, e_bz);
    if (!rst) begin
      if (mode == M_DONE && out_ready) m_hs++;
      if (a) begin
        mode = M_RUN;
        t0   = cyc;
        exp_q.push_back(cyc + LAT);
      end else if (mode == M_RUN && cyc - t0 == N + 1) begin
        mode = M_DONE;
      end else if (mode == M_DONE && out_ready) begin
        mode = M_IDLE;
      end
    end
  end

  // monitor: pops the expected completion cycle when a result appears
  bit seen = 0;
  int n_hs = 0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      seen = 0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1;
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("valid_latency", cyc, exp_q.pop_front());
      end
      if (out_valid && out_ready) begin
        n_hs++;
        seen = 0;
      end
    end
  end

  task automatic step(input bit iv, input bit ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    out_ready = ordy;
  endtask

  initial begin
    int bc, hs0, k;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) step(0, 0);

    // single sample, then held result under backpressure
    step(1, 0);
    bc = 0;
    repeat (100) begin
      step(0, 0);
      #3;
      if (busy) bc++;
    end
    chk("busy_cycles", bc, N + 1);
    hs0 = n_hs;
    step(0, 1);
    repeat (3) step(0, 0);
    chk("one_handshake", n_hs - hs0, 1);

    // back-to-back
    repeat (3 * LAT + 5) step(1, 1);
    repeat (LAT + 2) step(0, 1);

    // async reset mid-sweep
    step(1, 0);
    step(0, 0);
    k = 0;
    while (address !== 30 && k < 200) begin
      step(0, 0);
      k++;
    end
    chk("reach_addr30", k < 200, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_shift", shift, 0);
    chk("rst_flush", flush, 0);
    chk("rst_freeze", freeze, 1);
    chk("rst_address", address, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step(1, 1);
    repeat (LAT + 3) step(0, 1);

    // random traffic
    repeat (1500) step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    repeat (LAT + 4) step(0, 1);

    chk("sb_empty", exp_q.size(), 0);
    chk("hs_count", n_hs, m_hs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
